// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch prefetch queue.
// Queue entries carry the fetch PC, the fetched word and an invalid-address flag.
package if_pkg;

    localparam int          IF_XLEN_MAX = 64;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [IF_XLEN_MAX-1:0] pc;
        logic [31:0]            instr;
        logic                   inv_addr;
    } if_entry_t;

    // Ceiling log2 for sizing pointers, counters and address ports
    function automatic int if_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// Generic power-of-two FIFO with single-cycle flush; pointers wrap naturally.
// Push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module sync_fifo_flush
    import if_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head_data,
    output logic [if_clog2(DEPTH):0]    count
);

    localparam int PW = if_clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             full_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Qualify push/pop against occupancy so the pointers can never desynchronise
    always_comb begin
        full_s    = (count_r == (PW+1)'(DEPTH));
        pop_ok_s  = pop & (count_r != {(PW+1){1'b0}});
        push_ok_s = push & (~full_s | pop_ok_s);
    end

    // Pointer and occupancy update; flush empties the FIFO in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PW+1)'(1'b1);
                2'b01:   count_r <= count_r - (PW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch front end: PC generation, synchronous imem issue, one in-flight slot and
// a DEPTH-entry prefetch queue feeding decode, with one-cycle redirect flush.
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter int               XLEN       = 64,
    parameter int               DEPTH      = 4,
    parameter int               IMEM_WORDS = 1024,
    parameter logic [XLEN-1:0]  RESET_PC   = {XLEN{1'b0}}
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              redirect_valid,
    input  logic [XLEN-1:0]                   redirect_pc,
    output logic                              imem_req,
    output logic [if_clog2(IMEM_WORDS)-1:0]   imem_addr,
    input  logic [31:0]                       imem_rdata,
    output logic                              id_valid,
    input  logic                              id_ready,
    output logic [XLEN-1:0]                   id_pc,
    output logic [31:0]                       id_instr,
    output logic                              id_inv_addr,
    output logic [XLEN-1:0]                   fetch_pc,
    output logic [if_clog2(DEPTH):0]          count
);

    localparam int AW = if_clog2(IMEM_WORDS);
    localparam int CW = if_clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_r;
    logic            infl_valid_r;
    logic [XLEN-1:0] infl_pc_r;
    logic            infl_inv_r;
    logic            halted_r;

    logic [CW-1:0]   count_s;
    logic            pop_s;
    logic            push_s;
    logic            pc_inv_s;
    logic            credit_ok_s;
    logic            issue_s;
    logic [CW:0]     credit_used_s;
    logic [CW:0]     credit_limit_s;
    if_entry_t       push_entry_s;
    if_entry_t       head_entry_s;

    // Issue decision: in-flight fetch reserves a slot so the queue can never overflow
    always_comb begin
        pop_s          = (count_s != {CW{1'b0}}) & id_ready;
        pc_inv_s       = (fetch_pc_r[1:0] != 2'b00) ||
                         (fetch_pc_r[XLEN-1:2] >= (XLEN-2)'(IMEM_WORDS));
        credit_used_s  = {1'b0, count_s} + {{CW{1'b0}}, infl_valid_r};
        credit_limit_s = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop_s};
        credit_ok_s    = (credit_used_s < credit_limit_s);
        issue_s        = credit_ok_s & ~redirect_valid & ~halted_r & ~rst;
        push_s         = infl_valid_r & ~redirect_valid;
    end

    // Build the queue entry; a bad PC becomes a NOP tagged for a later fault
    always_comb begin
        push_entry_s          = {$bits(if_entry_t){1'b0}};
        push_entry_s.pc       = IF_XLEN_MAX'(infl_pc_r);
        push_entry_s.inv_addr = infl_inv_r;
        if (infl_inv_r) begin
            push_entry_s.instr = NOP_INSTR;
        end else begin
            push_entry_s.instr = imem_rdata;
        end
    end

    // PC, in-flight slot and halt flag; redirect overrides everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r   <= RESET_PC;
            infl_valid_r <= 1'b0;
            infl_pc_r    <= {XLEN{1'b0}};
            infl_inv_r   <= 1'b0;
            halted_r     <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_r   <= redirect_pc;
            infl_valid_r <= 1'b0;
            infl_inv_r   <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            infl_valid_r <= issue_s;
            if (issue_s) begin
                infl_pc_r  <= fetch_pc_r;
                infl_inv_r <= pc_inv_s;
                if (pc_inv_s) begin
                    halted_r <= 1'b1;
                end else begin
                    fetch_pc_r <= fetch_pc_r + XLEN'(3'd4);
                end
            end
        end
    end

    sync_fifo_flush #(
        .WIDTH ($bits(if_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .count     (count_s)
    );

    // Head presentation; an empty queue shows an all-zero bubble
    always_comb begin
        if (count_s != {CW{1'b0}}) begin
            id_valid    = 1'b1;
            id_pc       = head_entry_s.pc[XLEN-1:0];
            id_instr    = head_entry_s.instr;
            id_inv_addr = head_entry_s.inv_addr;
        end else begin
            id_valid    = 1'b0;
            id_pc       = {XLEN{1'b0}};
            id_instr    = 32'h0000_0000;
            id_inv_addr = 1'b0;
        end
    end

    assign imem_req  = issue_s & ~pc_inv_s;
    assign imem_addr = fetch_pc_r[AW+1:2];
    assign fetch_pc  = fetch_pc_r;
    assign count     = count_s;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: memory word i holds value i.
module tb_if_prefetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        id_inv_addr;
    logic [63:0] fetch_pc;
    logic [2:0]  count;

    int n_cmp;
    int n_err;

    if_prefetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_inv_addr    (id_inv_addr),
        .fetch_pc       (fetch_pc),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory model: word i = i
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'(imem_addr);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; id_ready = ready;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; id_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", id_valid); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (fetch_pc !== 64'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", fetch_pc); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_cmp++; if ({id_pc, id_instr, id_inv_addr} !== 97'h0) begin n_err++; $display("FAIL rst_bubble: pc %h instr %h inv %b want 0", id_pc, id_instr, id_inv_addr); end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        tick();
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL fill_valid: got %b want 0", id_valid); end
        n_cmp++; if (fetch_pc !== 64'h4) begin n_err++; $display("FAIL fill_pc: got %h want 4", fetch_pc); end
        tick();
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'(k*4) || id_instr !== 32'(k)) begin
                n_err++; $display("FAIL stream_%0d: valid %b pc %h instr %h want 1 %h %h", k, id_valid, id_pc, id_instr, 64'(k*4), 32'(k));
            end
            n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL stream_count_%0d: got %0d want 1", k, count); end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL stall_count: got %0d want 4", count); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req: got %b want 0", imem_req); end
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h0 || id_instr !== 32'h0) begin n_err++; $display("FAIL stall_head: valid %b pc %h instr %h want 1 0 0", id_valid, id_pc, id_instr); end
        n_cmp++; if (fetch_pc !== 64'h10) begin n_err++; $display("FAIL stall_fpc: got %h want 10", fetch_pc); end
        id_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'(j*4) || id_instr !== 32'(j)) begin
                n_err++; $display("FAIL drain_%0d: valid %b pc %h instr %h want 1 %h %h", j, id_valid, id_pc, id_instr, 64'(j*4), 32'(j));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL pre_redir_count: got %0d want 3", count); end
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        tick();
        n_cmp++; if (id_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL redir_flush: valid %b count %0d want 0 0", id_valid, count); end
        n_cmp++; if (fetch_pc !== 64'h100) begin n_err++; $display("FAIL redir_fpc: got %h want 100", fetch_pc); end
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'h40) begin n_err++; $display("FAIL redir_req: req %b addr %h want 1 40", imem_req, imem_addr); end
        tick();
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL redir_gap: got %b want 0", id_valid); end
        tick();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h100 || id_instr !== 32'h40) begin n_err++; $display("FAIL redir_first: valid %b pc %h instr %h want 1 100 40", id_valid, id_pc, id_instr); end
        id_ready = 1'b1;
        tick();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h104 || id_instr !== 32'h41) begin n_err++; $display("FAIL redir_second: valid %b pc %h instr %h want 1 104 41", id_valid, id_pc, id_instr); end
    endtask

    task automatic test_misaligned();
        do_reset(1'b1);
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 64'h102;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || fetch_pc !== 64'h102) begin n_err++; $display("FAIL mis_req: req %b fpc %h want 0 102", imem_req, fetch_pc); end
        tick(); tick();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h102 || id_inv_addr !== 1'b1 || id_instr !== 32'h13) begin
            n_err++; $display("FAIL mis_entry: valid %b pc %h inv %b instr %h want 1 102 1 13", id_valid, id_pc, id_inv_addr, id_instr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (id_valid !== 1'b0 || imem_req !== 1'b0 || fetch_pc !== 64'h102) begin
                n_err++; $display("FAIL mis_halt_%0d: valid %b req %b fpc %h want 0 0 102", i, id_valid, imem_req, fetch_pc);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h40 || id_instr !== 32'h10 || id_inv_addr !== 1'b0) begin
            n_err++; $display("FAIL mis_resume: valid %b pc %h instr %h inv %b want 1 40 10 0", id_valid, id_pc, id_instr, id_inv_addr);
        end
    endtask

    task automatic test_range();
        do_reset(1'b1);
        redirect_valid = 1'b1; redirect_pc = 64'hFF8;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (id_pc !== 64'hFF8 || id_instr !== 32'h3FE) begin n_err++; $display("FAIL range_ff8: pc %h instr %h want ff8 3fe", id_pc, id_instr); end
        tick();
        n_cmp++; if (id_pc !== 64'hFFC || id_instr !== 32'h3FF || id_inv_addr !== 1'b0) begin n_err++; $display("FAIL range_ffc: pc %h instr %h inv %b want ffc 3ff 0", id_pc, id_instr, id_inv_addr); end
        tick();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h1000 || id_inv_addr !== 1'b1 || id_instr !== 32'h13) begin
            n_err++; $display("FAIL range_oor: valid %b pc %h inv %b instr %h want 1 1000 1 13", id_valid, id_pc, id_inv_addr, id_instr);
        end
        n_cmp++; if (imem_req !== 1'b0 || fetch_pc !== 64'h1000) begin n_err++; $display("FAIL range_halt: req %b fpc %h want 0 1000", imem_req, fetch_pc); end
        tick();
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL range_empty: got %b want 0", id_valid); end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b0);
        tick(); tick(); tick();
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL mid_count: got %0d want 2", count); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (id_valid !== 1'b0 || count !== 3'd0 || imem_req !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctl: valid %b count %0d req %b want 0 0 0", id_valid, count, imem_req); end
        n_cmp++; if (fetch_pc !== 64'h0 || id_pc !== 64'h0 || id_instr !== 32'h0 || id_inv_addr !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_data: fpc %h pc %h instr %h inv %b want 0", fetch_pc, id_pc, id_instr, id_inv_addr);
        end
        @(negedge clk);
        rst = 1'b0; id_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h0 || id_instr !== 32'h0) begin n_err++; $display("FAIL mid_restart: valid %b pc %h instr %h want 1 0 0", id_valid, id_pc, id_instr); end
        tick();
        n_cmp++; if (id_pc !== 64'h4 || id_instr !== 32'h1) begin n_err++; $display("FAIL mid_restart2: pc %h instr %h want 4 1", id_pc, id_instr); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_range();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
